// File: rtl/i2c_target_if.sv
// I2C target pad and register-port bundle.
// The host side drives the raw pad levels and rd_data; the target drives the rest.
interface i2c_target_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       wr_strobe;
    logic [7:0] rd_data;
    logic       rd_strobe;
    logic       busy;

    modport slave (
        input  scl_in, sda_in, rd_data,
        output sda_oe, reg_addr, wr_data, wr_strobe, rd_strobe, busy
    );

    modport master (
        output scl_in, sda_in, rd_data,
        input  sda_oe, reg_addr, wr_data, wr_strobe, rd_strobe, busy
    );
endinterface

// File: rtl/i2c_target.sv
// I2C target with 8-bit register pointer; pads pass through a 2-flop sync plus FILTER_LEN glitch filter.
// sda_oe updates one cycle after a filtered SCL fall; wr_strobe follows the 8th data rise by one cycle.
// No clock stretching: rd_data must be valid combinationally during the rd_strobe cycle.
module i2c_target #(
    parameter logic [6:0] ADDRESS    = 7'h3A,
    parameter int         FILTER_LEN = 3
) (
    input logic         clock,
    input logic         reset,
    i2c_target_if.slave bus
);

    localparam int CW = $clog2(FILTER_LEN + 1);

    typedef enum logic [3:0] {
        IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WRITE, WRITE_ACK,
        READ, READ_ACK, READ_LOAD, WAIT_STOP
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    raw, sync_a, sync_b, filt, filt_q;
    logic [CW-1:0] flt_cnt [2];
    logic [7:0]    shift, reg_addr, wr_data;
    logic [3:0]    bit_cnt;
    logic          sda_drv, wr_stb, busy, rd_pulse;
    logic          scl_rise, scl_fall, start, stop, last_bit;
    logic [7:0]    rx_byte;

    // bit 1 carries SCL, bit 0 carries SDA
    assign raw = {bus.scl_in, bus.sda_in};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync_a     <= '1;
            sync_b     <= '1;
            filt       <= '1;
            filt_q     <= '1;
            flt_cnt[0] <= '0;
            flt_cnt[1] <= '0;
        end else begin
            sync_a <= raw;
            sync_b <= sync_a;
            filt_q <= filt;
            for (int i = 0; i < 2; i++) begin
                if (sync_b[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == CW'(FILTER_LEN - 1)) begin
                    filt[i]    <= sync_b[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + CW'(1);
                end
            end
        end
    end

    assign scl_rise = filt[1] & ~filt_q[1];
    assign scl_fall = ~filt[1] & filt_q[1];
    assign start    = ~filt[0] & filt_q[0] & filt[1] & filt_q[1];
    assign stop     = filt[0] & ~filt_q[0] & filt[1] & filt_q[1];
    assign last_bit = scl_rise && (bit_cnt == 4'd7);
    assign rx_byte  = {shift[6:0], filt[0]};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        rd_pulse  = 1'b0;
        if (stop) begin
            state_nxt = IDLE;
        end else if (start) begin
            state_nxt = ADDR;
        end else begin
            case (state)
                ADDR:      if (last_bit) state_nxt = (rx_byte[7:1] == ADDRESS) ? ADDR_ACK : IDLE;
                ADDR_ACK:  if (scl_fall && sda_drv) begin
                               // shift[0] still holds the R/W bit of the address byte
                               state_nxt = shift[0] ? READ : PTR;
                               rd_pulse  = shift[0];
                           end
                PTR:       if (last_bit) state_nxt = PTR_ACK;
                PTR_ACK:   if (scl_fall && sda_drv) state_nxt = WRITE;
                WRITE:     if (last_bit) state_nxt = WRITE_ACK;
                WRITE_ACK: if (scl_fall && sda_drv) state_nxt = WRITE;
                READ:      if (scl_fall && bit_cnt == 4'd8) state_nxt = READ_ACK;
                READ_ACK:  if (scl_rise) state_nxt = filt[0] ? WAIT_STOP : READ_LOAD;
                READ_LOAD: if (scl_fall) begin
                               state_nxt = READ;
                               rd_pulse  = 1'b1;
                           end
                default:   state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift    <= '0;
            bit_cnt  <= '0;
            sda_drv  <= 1'b0;
            reg_addr <= '0;
            wr_data  <= '0;
            wr_stb   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            wr_stb <= 1'b0;
            if (stop) begin
                sda_drv <= 1'b0;
                busy    <= 1'b0;
            end else if (start) begin
                sda_drv <= 1'b0;
                busy    <= 1'b0;
                bit_cnt <= '0;
            end else begin
                case (state)
                    ADDR, PTR, WRITE: if (scl_rise) begin
                        shift   <= rx_byte;
                        bit_cnt <= bit_cnt + 4'd1;
                        if (last_bit && state == ADDR && rx_byte[7:1] == ADDRESS) busy <= 1'b1;
                        if (last_bit && state == PTR) reg_addr <= rx_byte;
                        if (last_bit && state == WRITE) begin
                            wr_data <= rx_byte;
                            wr_stb  <= 1'b1;
                        end
                    end
                    // first fall after the byte drives ACK, the second releases it
                    ADDR_ACK, PTR_ACK, WRITE_ACK: if (scl_fall) begin
                        if (!sda_drv) begin
                            sda_drv <= 1'b1;
                        end else begin
                            sda_drv <= 1'b0;
                            bit_cnt <= '0;
                            if (state == WRITE_ACK) reg_addr <= reg_addr + 8'd1;
                        end
                    end
                    READ: begin
                        if (scl_rise) bit_cnt <= bit_cnt + 4'd1;
                        if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_drv <= 1'b0;
                            end else begin
                                sda_drv <= ~shift[6];
                                shift   <= {shift[6:0], 1'b0};
                            end
                        end
                    end
                    READ_ACK: if (scl_rise && !filt[0]) reg_addr <= reg_addr + 8'd1;
                    default: ;
                endcase
                if (rd_pulse) begin
                    shift   <= bus.rd_data;
                    sda_drv <= ~bus.rd_data[7];
                    bit_cnt <= '0;
                end
            end
        end
    end

    assign bus.sda_oe    = sda_drv;
    assign bus.reg_addr  = reg_addr;
    assign bus.wr_data   = wr_data;
    assign bus.wr_strobe = wr_stb;
    assign bus.rd_strobe = rd_pulse;
    assign bus.busy      = busy;

endmodule

// File: tb/tb_i2c_target.sv
// Directed bench for i2c_target: bit-banged master with open-drain SDA and a rd_data = addr ^ 0x5A register model.
module tb_i2c_target;

    localparam int Q = 10;  // clocks per quarter SCL period

    logic clock;
    logic reset;
    logic scl_m;
    logic sda_m;
    int   checks;
    int   errors;

    i2c_target_if bus ();

    i2c_target #(.ADDRESS(7'h3A), .FILTER_LEN(3)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    assign bus.scl_in  = scl_m;
    assign bus.sda_in  = sda_m & ~bus.sda_oe;
    assign bus.rd_data = bus.reg_addr ^ 8'h5A;

    always #5 clock = ~clock;

    logic [7:0] wr_addr_log [16];
    logic [7:0] wr_data_log [16];
    int wr_cnt, rd_cnt, oe_cnt, busy_cnt, both_cnt;

    always @(negedge clock) begin
        if (bus.wr_strobe) begin
            if (wr_cnt < 16) begin
                wr_addr_log[wr_cnt] = bus.reg_addr;
                wr_data_log[wr_cnt] = bus.wr_data;
            end
            wr_cnt = wr_cnt + 1;
        end
        if (bus.rd_strobe) rd_cnt = rd_cnt + 1;
        if (bus.sda_oe) oe_cnt = oe_cnt + 1;
        if (bus.busy) busy_cnt = busy_cnt + 1;
        if (bus.wr_strobe && bus.rd_strobe) both_cnt = both_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_bits(input logic [7:0] b, input int glitch_bit);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; tick(Q);
            scl_m = 1'b1;
            if (i == glitch_bit) begin
                tick(Q / 2);
                scl_m = 1'b0; tick(1);
                scl_m = 1'b1; tick(2 * Q - Q / 2 - 1);
            end else begin
                tick(2 * Q);
            end
            scl_m = 1'b0; tick(Q);
        end
    endtask

    task automatic ack_slot(output logic ack);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        ack = ~bus.sda_in; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input int glitch_bit, output logic ack);
        send_bits(b, glitch_bit);
        ack_slot(ack);
    endtask

    task automatic read_byte(input logic give_ack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; tick(Q);
            scl_m = 1'b1; tick(Q);
            b[i] = bus.sda_in; tick(Q);
            scl_m = 1'b0; tick(Q);
        end
        sda_m = ~give_ack; tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    initial begin
        logic       a0, a1, a2, a3;
        logic [7:0] rb;
        int         wr0, rd0, oe0, busy0;

        checks = 0; errors = 0;
        wr_cnt = 0; rd_cnt = 0; oe_cnt = 0; busy_cnt = 0; both_cnt = 0;
        clock = 1'b0; reset = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
        tick(3);
        check("rst_sda_oe",    bus.sda_oe,    1'b0);
        check("rst_reg_addr",  bus.reg_addr,  8'h00);
        check("rst_wr_data",   bus.wr_data,   8'h00);
        check("rst_wr_strobe", bus.wr_strobe, 1'b0);
        check("rst_rd_strobe", bus.rd_strobe, 1'b0);
        check("rst_busy",      bus.busy,      1'b0);
        reset = 1'b1;
        tick(Q);

        // two-byte write from pointer 0x10
        i2c_start();
        write_byte(8'h74, -1, a0);
        check("wr_busy_after_match", bus.busy, 1'b1);
        write_byte(8'h10, -1, a1);
        write_byte(8'hAB, -1, a2);
        write_byte(8'hCD, -1, a3);
        i2c_stop();
        tick(Q);
        check("wr_ack_count", 32'(a0) + 32'(a1) + 32'(a2) + 32'(a3), 32'd4);
        check("wr_strobe_count", wr_cnt, 2);
        check("wr0_addr", wr_addr_log[0], 8'h10);
        check("wr0_data", wr_data_log[0], 8'hAB);
        check("wr1_addr", wr_addr_log[1], 8'h11);
        check("wr1_data", wr_data_log[1], 8'hCD);
        check("wr_ptr_after", bus.reg_addr, 8'h12);
        check("wr_busy_after_stop", bus.busy, 1'b0);

        // pointer write, repeated START, three-byte read
        rd0 = rd_cnt; wr0 = wr_cnt;
        i2c_start();
        write_byte(8'h74, -1, a0);
        write_byte(8'h20, -1, a1);
        i2c_start();
        write_byte(8'h75, -1, a2);
        check("rd_acks", 32'(a0) + 32'(a1) + 32'(a2), 32'd3);
        read_byte(1'b1, rb);
        check("rd_byte0", rb, 8'h7A);
        read_byte(1'b1, rb);
        check("rd_byte1", rb, 8'h7B);
        read_byte(1'b0, rb);
        check("rd_byte2", rb, 8'h78);
        check("rd_busy_before_stop", bus.busy, 1'b1);
        i2c_stop();
        tick(Q);
        check("rd_strobe_count", rd_cnt - rd0, 3);
        check("rd_no_writes", wr_cnt - wr0, 0);
        check("rd_busy_after_stop", bus.busy, 1'b0);
        check("rd_ptr_after", bus.reg_addr, 8'h22);

        // foreign address 0x50 must be ignored entirely
        rd0 = rd_cnt; wr0 = wr_cnt; oe0 = oe_cnt; busy0 = busy_cnt;
        i2c_start();
        write_byte(8'hA0, -1, a0);
        write_byte(8'h55, -1, a1);
        i2c_stop();
        tick(Q);
        check("wa_ack", 32'(a0) + 32'(a1), 32'd0);
        check("wa_sda_oe_cycles", oe_cnt - oe0, 0);
        check("wa_strobes", (rd_cnt - rd0) + (wr_cnt - wr0), 0);
        check("wa_busy_cycles", busy_cnt - busy0, 0);
        check("wa_ptr", bus.reg_addr, 8'h22);

        // pointer wrap 0xFF -> 0x00
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'h74, -1, a0);
        write_byte(8'hFF, -1, a1);
        write_byte(8'h11, -1, a2);
        write_byte(8'h22, -1, a3);
        i2c_stop();
        tick(Q);
        check("wrap_acks", 32'(a0) + 32'(a1) + 32'(a2) + 32'(a3), 32'd4);
        check("wrap_count", wr_cnt - wr0, 2);
        check("wrap0_addr", wr_addr_log[wr0], 8'hFF);
        check("wrap0_data", wr_data_log[wr0], 8'h11);
        check("wrap1_addr", wr_addr_log[wr0 + 1], 8'h00);
        check("wrap1_data", wr_data_log[wr0 + 1], 8'h22);
        check("wrap_ptr", bus.reg_addr, 8'h01);

        // one-cycle SCL low glitch inside a data bit
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'h74, -1, a0);
        write_byte(8'h30, -1, a1);
        write_byte(8'h96, 4, a2);
        i2c_stop();
        tick(Q);
        check("gl_acks", 32'(a0) + 32'(a1) + 32'(a2), 32'd3);
        check("gl_count", wr_cnt - wr0, 1);
        check("gl_addr", wr_addr_log[wr0], 8'h30);
        check("gl_data", wr_data_log[wr0], 8'h96);

        // async reset while the address ACK is driven
        i2c_start();
        send_bits(8'h74, -1);
        sda_m = 1'b1; tick(Q);
        check("ar_ack_driven", bus.sda_oe, 1'b1);
        reset = 1'b0;
        #1;
        check("ar_sda_released", bus.sda_oe, 1'b0);
        check("ar_busy", bus.busy, 1'b0);
        check("ar_ptr", bus.reg_addr, 8'h00);
        tick(2);
        scl_m = 1'b1; sda_m = 1'b1;
        tick(4);
        reset = 1'b1;
        tick(Q);
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'h74, -1, a0);
        write_byte(8'h40, -1, a1);
        write_byte(8'h5C, -1, a2);
        i2c_stop();
        tick(Q);
        check("ar_post_acks", 32'(a0) + 32'(a1) + 32'(a2), 32'd3);
        check("ar_post_count", wr_cnt - wr0, 1);
        check("ar_post_addr", wr_addr_log[wr0], 8'h40);
        check("ar_post_data", wr_data_log[wr0], 8'h5C);
        check("ar_post_ptr", bus.reg_addr, 8'h41);

        check("strobes_overlap", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (responder) with an 8-bit register pointer and an external register interface.
- Lets an external host or bench master read and write lag-tester status and configuration registers over the same two-wire bus used to configure the DVI transmitter.
- Sits in the internal clock domain; the top level provides the open-drain pads.
- Supports standard/fast mode at system clock ≥ 20× SCL.

Parameters:
- ADDRESS, 7'h3A, 7-bit target address matched after START.
- FILTER_LEN, 3, consecutive equal synchronized samples required before a filtered SCL/SDA level changes.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- scl_in  in  1  raw SCL pad level.
- sda_in  in  1  raw SDA pad level.
- sda_oe  out  1  1 = drive SDA low (open-drain); 0 = release.
- reg_addr  out  8  current register pointer.
- wr_data  out  8  byte written by master.
- wr_strobe  out  1  one-cycle pulse; wr_data is valid for reg_addr.
- rd_data  in  8  register contents for reg_addr, sampled on rd_strobe.
- rd_strobe  out  1  one-cycle pulse requesting or latching rd_data.
- busy  out  1  high from own-address match until STOP or repeated START.

Behaviour:
- Reset (reset=0, async): sda_oe=0, reg_addr=0, wr_data=0, wr_strobe=0, rd_strobe=0, busy=0, state=IDLE, filters preset to 1.
- Input conditioning:
  - 2-flop synchronizer per line, then a glitch filter.
  - A filtered level changes only after FILTER_LEN equal samples.
  - Edges (scl_rise, scl_fall, sda edges) are single-cycle pulses derived from the filtered levels.
- START: filtered SDA falls while SCL=1. Accepted in any state, including mid-byte (repeated START). Goes to ADDR, bit counter=0, sda_oe=0.
- STOP: filtered SDA rises while SCL=1. Goes to IDLE from any state, sda_oe=0, busy=0. reg_addr retained.
- Bits are sampled on scl_rise, MSB first. sda_oe changes only on scl_fall, 1 cycle after the filtered edge.
- States:
  - IDLE: waits for START.
  - ADDR: shift 8 bits (7 address + R/W).
    - Match → ADDR_ACK, busy=1.
    - Mismatch → IDLE, bus released, no ACK.
  - ADDR_ACK:
    - Assert sda_oe on the scl_fall after the 8th bit; release it on the next scl_fall.
    - W → PTR.
    - R → pulse rd_strobe on the same scl_fall, load the shifter with rd_data in the next cycle, then READ.
  - PTR: shift 8 bits → reg_addr, then PTR_ACK (ACK as above), then WRITE.
  - WRITE: shift 8 bits. On the 8th scl_rise, wr_data=byte and wr_strobe pulses the next cycle. Then WRITE_ACK (always ACK). On the ACK-release scl_fall, reg_addr += 1.
  - READ:
    - Drive the shifter MSB first; sda_oe = ~bit, updated on each scl_fall.
    - After the 8th bit, release SDA and go to READ_ACK.
  - READ_ACK: sample master ACK on scl_rise.
    - ACK (SDA=0): reg_addr += 1. On the following scl_fall, pulse rd_strobe, reload the shifter, go to READ.
    - NACK: release the bus, go to IDLE-wait (ignore bits until STOP/START).
- reg_addr wraps 8'hFF → 8'h00, both on write and on read auto-increment.
- Read after write-pointer: the master sends W + PTR, then repeated START + R. Data comes from the new reg_addr.
- Clock stretching is not supported; SCL is never driven.
- Simultaneous START/STOP and bit edge in the same cycle: START/STOP take priority and the bit is discarded.
- wr_strobe and rd_strobe are never high in the same cycle.
- reset asserted mid-transfer: SDA is released immediately (combinational from async-cleared flop); no strobe is emitted.

Test Plan:
- Write 2 bytes: START, 0x74 (3A,W), ptr 0x10, 0xAB, 0xCD, STOP.
  → 4 ACKs.
  → wr_strobe with reg_addr=0x10/data=0xAB, then 0x11/0xCD.
  → reg_addr=0x12 after STOP.
- Read 3 bytes: rd_data model = addr^0x5A. START, 0x74, ptr 0x20, repeated START, 0x75, ACK, ACK, NACK, STOP.
  → bus bytes 0x7A, 0x7B, 0x78.
  → 3 rd_strobes.
  → busy low after STOP.
- Wrong address 0x50: START, 0xA0, data.
  → sda_oe never asserted, no strobes, busy=0.
- Pointer wrap: write ptr 0xFF, data 0x11, 0x22.
  → writes to 0xFF then 0x00.
- Glitch: a 1-cycle SCL low pulse during a data bit with FILTER_LEN=3.
  → ignored, byte received intact.
- Async reset while driving ACK.
  → sda_oe=0 in the same cycle, state IDLE.
  → a subsequent full write transaction succeeds.
